// File: rtl/lcm_unit.sv
// lcm_unit: computes lcm = (a / g) * b from an operand pair and its GCD.
// A bit-serial restoring divider produces a / g (and checks g divides a),
// then a bit-serial shift-add multiplier forms the 2*WIDTH-bit product.
// Results leave over a valid/ready handshake; err flags inconsistent input.
module lcm_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   g,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] lcm,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   a_r, b_r, g_r, quo;
  logic [WIDTH:0]     rem, rem_sh, rem_nx;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0]      cnt;
  logic               last;

  logic               ld_res;
  logic [2*WIDTH-1:0] res_lcm;
  logic               res_err;

  // One divider step and one multiplier step, both indexed MSB first by cnt.
  // rem stays below g, so its top bit is always clear before the shift.
  always_comb begin
    rem_sh = {rem[WIDTH-1:0], a_r[cnt]};
    rem_ge = (rem_sh >= {1'b0, g_r});
    rem_nx = rem_ge ? (rem_sh - {1'b0, g_r}) : rem_sh;
    acc_nx = {acc[2*WIDTH-2:0], 1'b0} + (quo[cnt] ? {{WIDTH{1'b0}}, b_r} : '0);
    last   = (cnt == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and the result to latch when DONE is entered.
  always_comb begin
    state_nx = state;
    ld_res   = 1'b0;
    res_lcm  = '0;
    res_err  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (a == '0 || b == '0) begin
            state_nx = DONE;
            ld_res   = 1'b1;
          end else if (g == '0) begin
            state_nx = DONE;
            ld_res   = 1'b1;
            res_err  = 1'b1;
          end else begin
            state_nx = DIV;
          end
        end
      end
      DIV: begin
        if (last) begin
          if (rem_nx != '0) begin
            state_nx = DONE;
            ld_res   = 1'b1;
            res_err  = 1'b1;
          end else begin
            state_nx = MUL;
          end
        end
      end
      MUL: begin
        if (last) begin
          state_nx = DONE;
          ld_res   = 1'b1;
          res_lcm  = acc_nx;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and the serial divide/multiply datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      g_r <= '0;
      quo <= '0;
      rem <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            g_r <= g;
            cnt <= CW'(WIDTH-1);
            rem <= '0;
            quo <= '0;
            acc <= '0;
          end
        end
        DIV: begin
          rem      <= rem_nx;
          quo[cnt] <= rem_ge;
          if (last) begin
            cnt <= CW'(WIDTH-1);
            acc <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MUL: begin
          acc <= acc_nx;
          if (!last) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded only when DONE is entered, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      lcm <= '0;
      err <= 1'b0;
    end else if (ld_res) begin
      lcm <= res_lcm;
      err <= res_err;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_lcm_unit.sv
// tb_lcm_unit: directed and randomized checks of lcm_unit against an
// arithmetic reference model (gcd/lcm computed with plain integer math).
module tb_lcm_unit;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b, g;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] lcm;
  logic           err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcm_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g(g), .out_valid(out_valid), .out_ready(out_ready),
    .lcm(lcm), .err(err)
  );

  function automatic int gcd_f(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Expected result and accept-to-valid latency (edges after the accept edge).
  function automatic void model(input int x, input int y, input int z,
                                output int el, output bit ee, output int elat);
    if (x == 0 || y == 0) begin
      el = 0; ee = 1'b0; elat = 0;
    end else if (z == 0) begin
      el = 0; ee = 1'b1; elat = 0;
    end else if (x % z != 0) begin
      el = 0; ee = 1'b1; elat = W;
    end else begin
      el = (x / z) * y; ee = 1'b0; elat = 2 * W;
    end
  endfunction

  // Drives one transaction; reports observed result, latency and whether any
  // handshake/stability rule was broken while busy or while held in DONE.
  task automatic run_op(input int x, input int y, input int z, input int hold,
                        output int lat, output logic [2*W-1:0] ol,
                        output logic oe, output bit bad);
    bad = 1'b0;
    @(negedge clk);
    if (!in_ready) bad = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = x[W-1:0]; b = y[W-1:0]; g = z[W-1:0];
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); g = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (in_ready) bad = 1'b1;
    ol = lcm;
    oe = err;
    repeat (hold) begin
      @(negedge clk);
      if (lcm !== ol || err !== oe || !out_valid || in_ready) bad = 1'b1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid || !in_ready || lcm !== ol || err !== oe) bad = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; g = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || lcm !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b lcm=%0d err=%b, want 1 0 0 0",
               in_ready, out_valid, lcm, err);
    end
  endtask

  task automatic test_directed();
    int ta[6]  = '{12, 255, 0, 9, 12, 12};
    int tb_[6] = '{18, 254, 77, 0, 18, 20};
    int tg[6]  = '{6, 1, 77, 9, 0, 5};
    int el[6]  = '{36, 64770, 0, 0, 0, 0};
    bit ee[6]  = '{0, 0, 0, 0, 1, 1};
    int elt[6] = '{16, 16, 0, 0, 0, 8};
    int lat; logic [2*W-1:0] ol; logic oe; bit bad;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb_[i], tg[i], 0, lat, ol, oe, bad);
      checks++;
      if (ol !== 16'(el[i]) || oe !== ee[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: lcm=%0d err=%b, want lcm=%0d err=%b",
                 i, ol, oe, el[i], ee[i]);
      end
      checks++;
      if (lat !== elt[i]) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, elt[i]);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL directed[%0d] handshake: rule violation seen, want none", i);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [2*W-1:0] ol; logic oe; bit bad;
    run_op(6, 4, 2, 10, lat, ol, oe, bad);
    checks++;
    if (ol !== 16'd12 || oe !== 1'b0 || bad) begin
      errors++;
      $display("FAIL backpressure: lcm=%0d err=%b bad=%b, want 12 0 0", ol, oe, bad);
    end
    // Next transaction goes out right after the release.
    run_op(6, 4, 2, 0, lat, ol, oe, bad);
    checks++;
    if (ol !== 16'd12 || lat !== 16 || bad) begin
      errors++;
      $display("FAIL backpressure_next: lcm=%0d lat=%0d bad=%b, want 12 16 0", ol, lat, bad);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [2*W-1:0] ol; logic oe; bit bad; bit seen;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd100; b = 8'd75; g = 8'd25;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || lcm !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: out_valid=%b lcm=%0d in_ready=%b, want 0 0 1",
               out_valid, lcm, in_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid seen=1, want 0");
    end
    run_op(8, 12, 4, 0, lat, ol, oe, bad);
    checks++;
    if (ol !== 16'd24 || oe !== 1'b0 || lat !== 16 || bad) begin
      errors++;
      $display("FAIL after_abort: lcm=%0d err=%b lat=%0d bad=%b, want 24 0 16 0",
               ol, oe, lat, bad);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    bit lcm_bad;
    lcm_bad = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd12; b = 8'd18; g = 8'd6;
    for (int c = 0; c < 60; c++) begin
      if (in_valid && in_ready) acc_cyc.push_back(c);
      if (out_valid && (lcm !== 16'd36 || err !== 1'b0)) lcm_bad = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !in_ready; c++) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() < 3 || acc_cyc[1] - acc_cyc[0] != 2*W+2 ||
        acc_cyc[2] - acc_cyc[1] != 2*W+2) begin
      errors++;
      $display("FAIL back_to_back period: accepts=%0d first gap=%0d, want >=3 and %0d",
               acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 2*W+2);
    end
    checks++;
    if (lcm_bad) begin
      errors++;
      $display("FAIL back_to_back result: wrong lcm/err seen, want 36/0");
    end
  endtask

  task automatic test_random();
    int x, y, z, el, elat, lat;
    bit ee, bad;
    logic [2*W-1:0] ol; logic oe;
    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if ($urandom_range(0, 9) < 7) z = gcd_f(x, y);
      else                          z = $urandom_range(0, 255);
      model(x, y, z, el, ee, elat);
      run_op(x, y, z, $urandom_range(0, 3), lat, ol, oe, bad);
      checks++;
      if (ol !== 16'(el) || oe !== ee) begin
        errors++;
        $display("FAIL random[%0d] a=%0d b=%0d g=%0d: lcm=%0d err=%b, want lcm=%0d err=%b",
                 i, x, y, z, ol, oe, el, ee);
      end
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL random[%0d] latency: got %0d, want %0d", i, lat, elat);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL random[%0d] handshake: rule violation seen, want none", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
